// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch shared types: colour, coordinate widths, timing constants.
// Also holds the RGB332 power-up palette used by pixel_palette.
package pixel_fetch_pkg;

  localparam int VERT_PIXELS  = 768;
  localparam int HORIZ_PIXELS = 1024;

  // 4x scaling: 1024 screen columns map onto 256 buffer columns
  localparam int COORD_W   = $clog2(HORIZ_PIXELS) - 2;
  localparam int FB_ADDR_W = 2 * COORD_W + 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic vid;
    logic hs;
    logic vs;
  } side_t;

  localparam side_t SIDE_IDLE = '{vid: 1'b0, hs: 1'b1, vs: 1'b1};

  typedef rgb444_t [255:0] pal_mem_t;

  function automatic rgb444_t rgb332(input logic [7:0] i);
    return rgb444_t'({i[7:5], i[7], i[4:2], i[4],
                      i[1:0], i[1:0]});
  endfunction

  function automatic pal_mem_t pal_init();
    pal_mem_t p;
    for (int i = 0; i < 256; i++) begin
      p[i] = rgb332(8'(i));
    end
    return p;
  endfunction

endpackage

// File: rtl/pixel_palette.sv
// pixel_palette: 256x12 colour lookup, one write and one read port.
// Read-first on same-index collision; contents survive reset.
module pixel_palette
  import pixel_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [11:0] wdata,
  input  logic [7:0]  raddr,
  output logic [11:0] rdata
);

  pal_mem_t mem = pal_init();

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_fetch.sv
// pixel_fetch: screen coord -> frame-buffer address -> palette RGB, 3 cycles.
// Optional 4x4 cursor block when PIXEL_FETCH_CURSOR_EN is defined.
module pixel_fetch #(
  parameter int SCALE_SHIFT = 2,
  parameter int VERT_PIXELS = pixel_fetch_pkg::VERT_PIXELS
`ifdef PIXEL_FETCH_CURSOR_EN
  ,
  parameter logic [11:0] CURSOR_COLOR = 12'hFFF
`endif
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        horiz_sync,
  input  logic        vert_sync,
  input  logic        video_on,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  input  logic        buf_sel,
  output logic [16:0] fb_addr,
  input  logic [7:0]  fb_data,
  input  logic        pal_we,
  input  logic [7:0]  pal_waddr,
  input  logic [11:0] pal_wdata,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue
`ifdef PIXEL_FETCH_CURSOR_EN
  ,
  input  logic [7:0]  cursor_x,
  input  logic [7:0]  cursor_y
`endif
);

  import pixel_fetch_pkg::*;

  coord_t  row_s;
  coord_t  col_s;
  logic    fs_det;
  logic    buf_q;
  side_t   s1;
  side_t   s2;
  side_t   s3;
  logic [11:0] pal_q;
  rgb444_t rgb;

  assign row_s  = coord_t'(pixel_row >> SCALE_SHIFT);
  assign col_s  = coord_t'(pixel_column >> SCALE_SHIFT);
  assign fs_det = (pixel_row == 12'(VERT_PIXELS))
               && (pixel_column == '0);

  always_ff @(posedge clock) begin
    if (rst) begin
      fb_addr     <= '0;
      buf_q       <= 1'b0;
      frame_start <= 1'b0;
      s1          <= SIDE_IDLE;
      s2          <= SIDE_IDLE;
      s3          <= SIDE_IDLE;
    end else begin
      fb_addr     <= video_on ? {buf_q, row_s, col_s} : '0;
      frame_start <= fs_det;
      // buffer swap only at vblank start, so no tearing
      if (fs_det) begin
        buf_q <= buf_sel;
      end
      s1 <= '{vid: video_on, hs: horiz_sync, vs: vert_sync};
      s2 <= s1;
      s3 <= s2;
    end
  end

  pixel_palette u_pal (
    .clock (clock),
    .we    (pal_we),
    .waddr (pal_waddr),
    .wdata (pal_wdata),
    .raddr (fb_data),
    .rdata (pal_q)
  );

`ifdef PIXEL_FETCH_CURSOR_EN
  coord_t cur_x_q;
  coord_t cur_y_q;
  coord_t row1;
  coord_t col1;
  coord_t row2;
  coord_t col2;
  logic   hit3;

  always_ff @(posedge clock) begin
    if (rst) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      row1    <= '0;
      col1    <= '0;
      row2    <= '0;
      col2    <= '0;
      hit3    <= 1'b0;
    end else begin
      if (fs_det) begin
        cur_x_q <= cursor_x;
        cur_y_q <= cursor_y;
      end
      row1 <= row_s;
      col1 <= col_s;
      row2 <= row1;
      col2 <= col1;
      hit3 <= (row2 == cur_y_q) && (col2 == cur_x_q);
    end
  end

  always_comb begin
    rgb = '0;
    unique case (1'b1)
      !s3.vid: rgb = '0;
      hit3:    rgb = rgb444_t'(CURSOR_COLOR);
      default: rgb = rgb444_t'(pal_q);
    endcase
  end
`else
  always_comb begin
    rgb = '0;
    if (s3.vid) begin
      rgb = rgb444_t'(pal_q);
    end
  end
`endif

  assign vga_hsync = s3.hs;
  assign vga_vsync = s3.vs;
  assign vga_red   = rgb.r;
  assign vga_green = rgb.g;
  assign vga_blue  = rgb.b;

endmodule
